// File: rtl/pio_bank_if.sv
// pio_bank_if: Avalon-MM slave bus bundle for pio_bank.
//   avs_address        5-bit word address
//   avs_read/avs_write read and write strobes (no waitrequest)
//   avs_writedata      32-bit write data
//   avs_readdata       32-bit registered read data
//   avs_readdatavalid  one-cycle pulse after an accepted read
// Modports: master (the NIOS side / bench), slave (pio_bank).
interface pio_bank_if;
  logic [4:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;
  logic        avs_readdatavalid;

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata,
    input  avs_readdata, avs_readdatavalid
  );

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata,
    output avs_readdata, avs_readdatavalid
  );
endinterface

// File: rtl/pio_bank.sv
// pio_bank: NCH general-purpose output channels plus a debounced, edge-capturing
// key input with a maskable interrupt, on one Avalon-MM slave.
// Ports:
//   clk_clk      system clock, rising edge
//   reset_reset  synchronous active-high reset
//   avs          pio_bank_if.slave bus (address/read/write/writedata/readdata/readdatavalid)
//   pio_out      NCH*W outputs, channel c at [c*W +: W]
//   key_in       IN_W raw asynchronous key inputs
//   irq          |(EDGE & MASK)
// Register map (word addresses): 0..NCH-1 OUT[c], 13 DIN, 14 MASK, 15 EDGE (W1C).
// Optional macro PIO_BANK_SETCLR_EN: 16+c SET[c] (OR-in), 24+c CLR[c] (AND-out),
// both read back OUT[c]; without it 16..31 are unmapped.
module pio_bank #(
  parameter int          NCH             = 3,
  parameter int          W               = 16,
  parameter int          IN_W            = 2,
  parameter int          DEBOUNCE_CYCLES = 50000,
  parameter int          EDGE_MODE       = 1,
  parameter int unsigned OUT_RESET       = 0
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  pio_bank_if.slave         avs,
  output logic [NCH*W-1:0]  pio_out,
  input  logic [IN_W-1:0]   key_in,
  output logic              irq
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;

  logic [W-1:0]    out_r [NCH];
  logic [IN_W-1:0] mask_r, edge_r;
  logic [IN_W-1:0] s1_r, s2_r, din_r, din_prev_r;
  logic [CW-1:0]   cnt_r [IN_W];
  logic [31:0]     readdata_r;
  logic            rvalid_r;

  logic [2:0]      ch_idx_s;
  logic            ch_hit_s, set_hit_s, clr_hit_s;
  logic [W-1:0]    ch_rd_s;
  logic [31:0]     rd_s;
  logic [IN_W-1:0] edge_set_s, edge_clr_s;
  logic            unused_wdata_s;

  assign ch_idx_s = avs.avs_address[2:0];

  // Writedata bits beyond each register's width are intentionally dropped.
  assign unused_wdata_s = ^avs.avs_writedata;

  // Decode which channel alias (plain, set, clear) the address selects.
  always_comb begin
    ch_hit_s  = 1'b0;
    set_hit_s = 1'b0;
    clr_hit_s = 1'b0;
    case (avs.avs_address[4:3])
      2'b00:   ch_hit_s  = (32'(ch_idx_s) < 32'(NCH));
`ifdef PIO_BANK_SETCLR_EN
      2'b10:   set_hit_s = (32'(ch_idx_s) < 32'(NCH));
      2'b11:   clr_hit_s = (32'(ch_idx_s) < 32'(NCH));
`endif
      default: ch_hit_s  = 1'b0;
    endcase
  end

  // Read mux from the current (pre-write) register values.
  always_comb begin
    ch_rd_s = '0;
    for (int c = 0; c < NCH; c++) begin
      ch_rd_s = (ch_idx_s == 3'(c)) ? out_r[c] : ch_rd_s;
    end
    case (avs.avs_address)
      5'd13:   rd_s = 32'(din_r);
      5'd14:   rd_s = 32'(mask_r);
      5'd15:   rd_s = 32'(edge_r);
      default: rd_s = (ch_hit_s | set_hit_s | clr_hit_s) ? 32'(ch_rd_s) : 32'd0;
    endcase
  end

  // Qualifying DIN transitions and W1C clear mask for the EDGE register.
  always_comb begin
    case (EDGE_MODE)
      0:       edge_set_s = din_r & ~din_prev_r;
      1:       edge_set_s = ~din_r & din_prev_r;
      2:       edge_set_s = din_r ^ din_prev_r;
      default: edge_set_s = '0;
    endcase
    if (avs.avs_write && (avs.avs_address == 5'd15)) begin
      edge_clr_s = avs.avs_writedata[IN_W-1:0];
    end else begin
      edge_clr_s = '0;
    end
  end

  // Bus-side registers: channels, mask, sticky edges, read response.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      for (int c = 0; c < NCH; c++) out_r[c] <= W'(OUT_RESET);
      mask_r     <= '0;
      edge_r     <= '0;
      readdata_r <= 32'd0;
      rvalid_r   <= 1'b0;
    end else begin
      rvalid_r <= avs.avs_read;
      if (avs.avs_read) readdata_r <= rd_s;
      for (int c = 0; c < NCH; c++) begin
        if (avs.avs_write && (ch_idx_s == 3'(c))) begin
          if (ch_hit_s)       out_r[c] <= avs.avs_writedata[W-1:0];
          else if (set_hit_s) out_r[c] <= out_r[c] | avs.avs_writedata[W-1:0];
          else if (clr_hit_s) out_r[c] <= out_r[c] & ~avs.avs_writedata[W-1:0];
        end
      end
      if (avs.avs_write && (avs.avs_address == 5'd14)) mask_r <= avs.avs_writedata[IN_W-1:0];
      // A set in the same cycle as a clear wins.
      edge_r <= (edge_r & ~edge_clr_s) | edge_set_s;
    end
  end

  // Input path: two-flop synchroniser then per-bit debounce into DIN.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      s1_r       <= '0;
      s2_r       <= '0;
      din_r      <= '0;
      din_prev_r <= '0;
      for (int i = 0; i < IN_W; i++) cnt_r[i] <= '0;
    end else begin
      s1_r       <= key_in;
      s2_r       <= s1_r;
      din_prev_r <= din_r;
      for (int i = 0; i < IN_W; i++) begin
        if (s2_r[i] == din_r[i]) begin
          cnt_r[i] <= '0;
        end else if (cnt_r[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          din_r[i] <= s2_r[i];
          cnt_r[i] <= '0;
        end else begin
          cnt_r[i] <= cnt_r[i] + CW'(1);
        end
      end
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_out
    assign pio_out[c*W +: W] = out_r[c];
  end

  assign avs.avs_readdata      = readdata_r;
  assign avs.avs_readdatavalid = rvalid_r;
  assign irq                   = |(edge_r & mask_r);
endmodule

// File: tb/tb_pio_bank.sv
module tb_pio_bank;
  logic        clk_clk = 1'b0;
  logic        reset_reset = 1'b1;
  logic [47:0] pio_out;
  logic [1:0]  key_in = 2'b11;
  logic        irq;

  pio_bank_if avs();

  pio_bank #(
    .NCH(3), .W(16), .IN_W(2), .DEBOUNCE_CYCLES(4), .EDGE_MODE(1), .OUT_RESET(32'h00AA)
  ) dut (
    .clk_clk(clk_clk), .reset_reset(reset_reset), .avs(avs),
    .pio_out(pio_out), .key_in(key_in), .irq(irq)
  );

  always #5 clk_clk = ~clk_clk;

  int          n_checks = 0;
  int          n_pass = 0;
  logic [31:0] sb_q[$];
  logic [47:0] exp_out;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
  endtask

  task automatic bus_read(input logic [4:0] a, input logic [31:0] e);
    avs.avs_address = a;
    avs.avs_read = 1'b1;
    sb_q.push_back(e);
    @(negedge clk_clk);
    avs.avs_read = 1'b0;
  endtask

  task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
    avs.avs_address = a;
    avs.avs_writedata = d;
    avs.avs_write = 1'b1;
    @(negedge clk_clk);
    avs.avs_write = 1'b0;
  endtask

  task automatic bus_rw(input logic [4:0] a, input logic [31:0] d, input logic [31:0] e);
    avs.avs_address = a;
    avs.avs_writedata = d;
    avs.avs_write = 1'b1;
    avs.avs_read = 1'b1;
    sb_q.push_back(e);
    @(negedge clk_clk);
    avs.avs_write = 1'b0;
    avs.avs_read = 1'b0;
  endtask

  // Response monitor: valid exactly one edge after each accepted read, data from the scoreboard.
  always @(posedge clk_clk) begin
    logic exp_valid;
    exp_valid = avs.avs_read && !reset_reset;
    #1;
    if (exp_valid || avs.avs_readdatavalid) begin
      check("rvalid", avs.avs_readdatavalid, exp_valid);
      if (avs.avs_readdatavalid) begin
        if (sb_q.size() == 0) check("sb_nonempty", sb_q.size(), 1);
        else check("readdata", avs.avs_readdata, sb_q.pop_front());
      end
    end
  end

  initial begin
    avs.avs_address = 5'd0;
    avs.avs_read = 1'b0;
    avs.avs_write = 1'b0;
    avs.avs_writedata = 32'd0;
    exp_out = 48'h00AA_00AA_00AA;

    // Reset held for three edges.
    repeat (3) @(negedge clk_clk);
    check("rst_pio_out", pio_out, exp_out);
    check("rst_irq", irq, 1'b0);
    check("rst_rvalid", avs.avs_readdatavalid, 1'b0);
    reset_reset = 1'b0;

    bus_read(5'd1, 32'h0000_00AA);

    // Channel write with upper writedata bits ignored.
    bus_write(5'd2, 32'hFFFF_1234);
    exp_out[32 +: 16] = 16'h1234;
    check("ch2_write", pio_out, exp_out);
    bus_read(5'd2, 32'h0000_1234);

    // Keys idle high: DIN settles to 11 with no falling edge captured.
    repeat (10) @(negedge clk_clk);
    bus_read(5'd13, 32'd3);
    bus_read(5'd15, 32'd0);
    bus_write(5'd14, 32'd1);

    // Clean falling edge on key 0: DIN falls on edge 6, EDGE/irq on edge 7.
    key_in[0] = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      avs.avs_address = 5'd13;
      avs.avs_read = 1'b1;
      sb_q.push_back((i <= 6) ? 32'd3 : 32'd2);
      @(negedge clk_clk);
      check("deb_irq", irq, (i >= 7) ? 1'b1 : 1'b0);
    end
    avs.avs_read = 1'b0;
    bus_read(5'd15, 32'd1);

    // W1C drops irq.
    bus_write(5'd15, 32'd1);
    check("w1c_irq", irq, 1'b0);

    // Key 0 back high (rising ignored), then a 3-cycle glitch.
    key_in[0] = 1'b1;
    repeat (10) @(negedge clk_clk);
    key_in[0] = 1'b0;
    repeat (3) @(negedge clk_clk);
    key_in[0] = 1'b1;
    repeat (10) @(negedge clk_clk);
    bus_read(5'd13, 32'd3);
    bus_read(5'd15, 32'd0);
    check("glitch_irq", irq, 1'b0);

    // Edge set on the same edge as a W1C of that bit: set wins.
    key_in[0] = 1'b0;
    repeat (6) @(negedge clk_clk);
    bus_write(5'd15, 32'd1);
    check("setwins_irq", irq, 1'b1);
    bus_read(5'd15, 32'd1);
    bus_write(5'd15, 32'd1);

    // Mask gating: EDGE=2 with MASK=1, then MASK=3.
    key_in[1] = 1'b0;
    repeat (10) @(negedge clk_clk);
    bus_read(5'd15, 32'd2);
    check("masked_irq", irq, 1'b0);
    bus_write(5'd14, 32'hFFFF_FFFF);
    check("unmask_irq", irq, 1'b1);
    bus_read(5'd14, 32'd3);

    // Read and write in the same cycle return the pre-write value.
    bus_rw(5'd0, 32'h0000_5555, 32'h0000_00AA);
    exp_out[0 +: 16] = 16'h5555;
    check("rw_pio_out", pio_out, exp_out);

    // Unmapped addresses.
    bus_write(5'd3, 32'h0000_BEEF);
    bus_read(5'd3, 32'd0);
    bus_read(5'd10, 32'd0);
    check("unmapped_pio_out", pio_out, exp_out);

    // Set/clear aliases.
    bus_write(5'd0, 32'h0000_00F0);
    exp_out[0 +: 16] = 16'h00F0;
    bus_write(5'd16, 32'h0000_000F);
`ifdef PIO_BANK_SETCLR_EN
    exp_out[0 +: 16] = 16'h00FF;
    check("set_pio_out", pio_out, exp_out);
    bus_read(5'd16, 32'h0000_00FF);
    bus_write(5'd24, 32'h0000_00F0);
    exp_out[0 +: 16] = 16'h000F;
    check("clr_pio_out", pio_out, exp_out);
    bus_read(5'd24, 32'h0000_000F);
`else
    check("noset_pio_out", pio_out, exp_out);
    bus_read(5'd16, 32'd0);
`endif

    // Reset again clears everything back.
    repeat (3) @(negedge clk_clk);
    reset_reset = 1'b1;
    repeat (2) @(negedge clk_clk);
    exp_out = 48'h00AA_00AA_00AA;
    check("rst2_pio_out", pio_out, exp_out);
    check("rst2_irq", irq, 1'b0);
    reset_reset = 1'b0;
    bus_read(5'd14, 32'd0);
    bus_read(5'd15, 32'd0);

    for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk_clk);
    check("sb_drain", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
